uart_tx_sched: RTL



---
 rtl/uart_tx_sched_if.sv | 28 ++
 rtl/uart_tx_sched.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester handshake and transmitter-side signals of the shared UART scheduler.
// The scheduler takes the slave view; the requesters and transmitter drive through the master view.
interface uart_tx_sched_if #(
  parameter int D_W   = 8,
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*D_W-1:0] req_data;
  logic [N_REQ-1:0]     req_ready;
  logic [D_W-1:0]       tx_data;
  logic                 tx_start;
  logic                 tx_done;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_data, tx_start, grant_id, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_data, tx_start, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers,
// with a watchdog that abandons a frame whose done pulse never arrives.
module uart_tx_sched #(
  parameter int D_W         = 8,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_sched_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_grant_id;
  logic [D_W-1:0]   r_tx_data;
  logic [WD_W-1:0]  r_wdog;
  logic             r_busy;
  logic             r_tx_start;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_cand;
  logic             w_found;
  logic             w_accept;
  logic             w_timeout;
  logic [N_REQ-1:0] w_ready;
  logic [D_W-1:0]   w_bytes [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_bytes[i] = bus.req_data[i*D_W +: D_W];
    end
  end

  // Search starts just after the last winner, so a continuous requester waits at most N_REQ-1 grants.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first, so no path infers a latch.
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst && w_found) begin
          w_ready     = N_REQ'(1) << w_winner;
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done pulse on the final watchdog cycle wins over the abort.
        if (bus.tx_done) begin
          w_state_nxt = S_IDLE;
        end else if (r_wdog == WD_LAST) begin
          w_timeout   = !rst;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= PTR_RST;
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_wdog     <= '0;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != S_IDLE);
      r_tx_start <= (w_state_nxt == S_START);
      if (w_accept) begin
        r_ptr      <= w_winner;
        r_grant_id <= w_winner;
        r_tx_data  <= w_bytes[w_winner];
      end
      if (r_state == S_START) begin
        r_wdog <= '0;
      end else if (r_state == S_WAIT_DONE && r_wdog != WD_LAST) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_start    = r_tx_start;
  assign bus.grant_id    = r_grant_id;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = w_timeout;
endmodule
